i2c_slave_device: RTL
=====================

Name: i2c_slave_device

Overview:
- I2C target (slave) endpoint that answers the team's I2C master driver on the shared scl/sda pair. It oversamples the bus with the system clock.
- Supports the master's two transaction forms. Write: S, addr+W, regAddr, data(s), P. Read: S, addr+W, regAddr, Sr, addr+R, data(s), NACK, P.
- Holds a small byte register file. Write commits are reported to local logic, and local logic has a read port into the file.

Parameters:
- DEV_ADDR, 7'h50, 7-bit bus address this target answers to.
- REG_AW, 4, register-file index width; depth = 2**REG_AW bytes.

Ports:
- clk  input  1  system clock; frequency ≥ 10× scl.
- rst  input  1  asynchronous, active-low reset.
- scl  input  1  bus clock from the master.
- sda  inout  1  open-drain data; the block drives only 1'b0 or 1'bz.
- busy  output  1  high from an address-matched START until STOP or NACK-terminated release.
- wrStrobe  output  1  one-clk pulse per committed write byte.
- wrAddr  output  8  register address of the committed byte.
- wrData  output  8  committed byte.
- hostRdAddr  input  REG_AW  local read index.
- hostRdData  output  8  regfile[hostRdAddr], combinational.

Behaviour:
- Reset (rst=0, async): all state is cleared immediately.
  - sda released (Z); busy=0; wrStrobe=0; wrAddr=0; wrData=0.
  - Regfile cleared to 8'h00; FSM goes to IDLE.
- Input conditioning: scl and sda each pass through a 2-flop synchronizer. Edges are detected on the synchronized values.
  - START: sda falls while scl is high.
  - STOP: sda rises while scl is high.
- Bit timing:
  - Bits are sampled on the scl rising edge, MSB first.
  - The target changes its sda drive 1 clk after a detected scl falling edge. It never changes sda while scl is high.
- States: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
- START in any state: load a fresh bit counter and go to DEV_ADDR (repeated start). Register pointer is kept.
- STOP in any state: go to IDLE, release sda, busy=0.
- DEV_ADDR: shift 8 bits.
  - addr[7:1]==DEV_ADDR → DEV_ACK, busy=1.
  - Otherwise → IGNORE. sda stays released and busy is unchanged (0).
- DEV_ACK:
  - Drive sda=0 from the scl fall after bit 8 until the next scl fall.
  - Then R/W=0 → REG_ADDR.
  - R/W=1 → RD_DATA, loading shift register from regfile[ptr].
- REG_ADDR: shift 8 bits, ptr←byte[REG_AW-1:0], keep the full byte for wrAddr → REG_ACK (ACK as above) → WR_DATA.
  - Indices ≥ depth are ACKed and use the low bits.
- WR_DATA / WR_ACK:
  - After 8 bits: regfile[ptr]←byte, wrStrobe=1 for exactly one clk, wrAddr={full regAddr byte high bits, ptr}, wrData=byte.
  - ACK the byte, then ptr←ptr+1 (wraps mod 2**REG_AW) → WR_DATA for burst.
- RD_DATA:
  - Drive each bit: 0 → sda=0, 1 → Z. After the 8th bit, release sda → RD_ACK.
- RD_ACK: sample master ACK on the scl rise.
  - ACK(0): ptr←ptr+1 (wrap), load next byte → RD_DATA.
  - NACK(1): → IGNORE and wait for STOP/START.
- IGNORE: sda released; only START/STOP are acted on.
- A write byte interrupted by START/STOP before its 8th bit is discarded: no strobe, no regfile change.
- hostRdData reflects a write on the clk after the commit.
- A local read and a bus write may occur in the same cycle with no arbitration. The local read returns the old value that cycle.

Test Plan:
- Write: S, 8'hA0, 8'h03, 8'h5A, P → three ACKs (sda=0 in each 9th-bit high phase); wrStrobe one pulse with wrAddr=8'h03, wrData=8'h5A; hostRdAddr=3 → hostRdData=8'h5A; busy 1→0 at STOP.
- Read: preload reg 3=8'h5A, then S, 8'hA0, 8'h03, Sr, 8'hA1, master NACK, P → 3 ACKs; bus bits 0,1,0,1,1,0,1,0; sda released after NACK; no wrStrobe.
- Address mismatch: S, 8'hA2, 8'h03, 8'hFF, P → sda never driven low; busy stays 0; no wrStrobe; regfile unchanged.
- Burst with wrap: S, 8'hA0, 8'h0F, 8'h11, 8'h22, P → reg15=8'h11, reg0=8'h22; two strobes with wrAddr 8'h0F then 8'h00. Burst read of 2 bytes from 8'h0F with ACK then NACK → 8'h11, 8'h22.
- Abort: S, 8'hA0, 8'h05, 4 data bits, P → no strobe; reg5 unchanged; IDLE.
- Async reset mid-RD_DATA while driving 0: rst=0 → sda=Z and busy=0 in the same cycle; regfile reads 8'h00; a following full write transaction succeeds.

Source files
------------

// File: rtl/i2c_slave_device.sv
// I2C target endpoint with a byte register file, oversampling scl/sda on the system clock.
// Bus writes are reported to local logic; local logic reads the file through a combinational port.
module i2c_slave_device #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         REG_AW   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl,
    inout  wire               sda,
    output logic              busy,
    output logic              wrStrobe,
    output logic [7:0]        wrAddr,
    output logic [7:0]        wrData,
    input  logic [REG_AW-1:0] hostRdAddr,
    output logic [7:0]        hostRdData
);

    localparam int                DEPTH    = 1 << REG_AW;
    localparam logic [7:0]        PTR_MASK = 8'(DEPTH - 1);
    localparam logic [REG_AW-1:0] PTR_ONE  = REG_AW'(1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_DEV_ADDR, ST_DEV_ACK, ST_REG_ADDR, ST_REG_ACK,
        ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK, ST_IGNORE
    } state_t;

    state_t            state_r;
    logic [1:0]        sclSync_r;
    logic [1:0]        sdaSync_r;
    logic              sclPrev_r;
    logic              sdaPrev_r;
    logic [7:0]        regFile_r [DEPTH];
    logic [6:0]        shift_r;
    logic [7:0]        regByte_r;
    logic [REG_AW-1:0] ptr_r;
    logic [2:0]        bitCnt_r;
    logic              ackOn_r;
    logic              rw_r;
    logic              sdaLow_r;

    logic              sclNow_s;
    logic              sdaNow_s;
    logic              sclRise_s;
    logic              sclFall_s;
    logic              startDet_s;
    logic              stopDet_s;
    logic [7:0]        shiftIn_s;
    logic [7:0]        wrAddrNext_s;
    logic [7:0]        rdByte_s;

    assign sclNow_s     = sclSync_r[1];
    assign sdaNow_s     = sdaSync_r[1];
    assign sclRise_s    = sclNow_s & ~sclPrev_r;
    assign sclFall_s    = ~sclNow_s & sclPrev_r;
    assign startDet_s   = sclNow_s & sclPrev_r & sdaPrev_r & ~sdaNow_s;
    assign stopDet_s    = sclNow_s & sclPrev_r & ~sdaPrev_r & sdaNow_s;
    assign shiftIn_s    = {shift_r, sdaNow_s};
    assign wrAddrNext_s = (regByte_r & ~PTR_MASK) | 8'(ptr_r);
    assign rdByte_s     = regFile_r[ptr_r];

    assign sda        = sdaLow_r ? 1'b0 : 1'bz;
    assign hostRdData = regFile_r[hostRdAddr];

    // Two-flop synchronizers plus one history stage for edge detection; idle bus is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclSync_r <= 2'b11;
            sdaSync_r <= 2'b11;
            sclPrev_r <= 1'b1;
            sdaPrev_r <= 1'b1;
        end else begin
            sclSync_r <= {sclSync_r[0], scl};
            sdaSync_r <= {sdaSync_r[0], sda};
            sclPrev_r <= sclNow_s;
            sdaPrev_r <= sdaNow_s;
        end
    end

    // Protocol FSM, register file and registered bus/host outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            shift_r   <= 7'h00;
            regByte_r <= 8'h00;
            ptr_r     <= '0;
            bitCnt_r  <= 3'd0;
            ackOn_r   <= 1'b0;
            rw_r      <= 1'b0;
            sdaLow_r  <= 1'b0;
            busy      <= 1'b0;
            wrStrobe  <= 1'b0;
            wrAddr    <= 8'h00;
            wrData    <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                regFile_r[i] <= 8'h00;
            end
        end else begin
            wrStrobe <= 1'b0;
            if (startDet_s) begin
                state_r  <= ST_DEV_ADDR;
                bitCnt_r <= 3'd0;
                ackOn_r  <= 1'b0;
                sdaLow_r <= 1'b0;
            end else if (stopDet_s) begin
                state_r  <= ST_IDLE;
                ackOn_r  <= 1'b0;
                sdaLow_r <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state_r)
                    ST_DEV_ADDR: begin
                        if (sclRise_s) begin
                            shift_r  <= shiftIn_s[6:0];
                            bitCnt_r <= bitCnt_r + 3'd1;
                            if (bitCnt_r == 3'd7) begin
                                if (shiftIn_s[7:1] == DEV_ADDR) begin
                                    state_r <= ST_DEV_ACK;
                                    busy    <= 1'b1;
                                    rw_r    <= shiftIn_s[0];
                                end else begin
                                    state_r <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_REG_ADDR: begin
                        if (sclRise_s) begin
                            shift_r  <= shiftIn_s[6:0];
                            bitCnt_r <= bitCnt_r + 3'd1;
                            if (bitCnt_r == 3'd7) begin
                                regByte_r <= shiftIn_s;
                                ptr_r     <= shiftIn_s[REG_AW-1:0];
                                state_r   <= ST_REG_ACK;
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        // Commit only on the 8th bit; a START/STOP earlier drops the partial byte.
                        if (sclRise_s) begin
                            shift_r  <= shiftIn_s[6:0];
                            bitCnt_r <= bitCnt_r + 3'd1;
                            if (bitCnt_r == 3'd7) begin
                                regFile_r[ptr_r] <= shiftIn_s;
                                wrStrobe         <= 1'b1;
                                wrAddr           <= wrAddrNext_s;
                                wrData           <= shiftIn_s;
                                state_r          <= ST_WR_ACK;
                            end
                        end
                    end
                    ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: begin
                        // First scl fall asserts the ACK, second one ends the ACK clock.
                        if (sclFall_s) begin
                            if (!ackOn_r) begin
                                ackOn_r  <= 1'b1;
                                sdaLow_r <= 1'b1;
                            end else begin
                                ackOn_r  <= 1'b0;
                                bitCnt_r <= 3'd0;
                                sdaLow_r <= 1'b0;
                                if (state_r == ST_WR_ACK) begin
                                    ptr_r <= ptr_r + PTR_ONE;
                                end
                                if (state_r == ST_DEV_ACK && rw_r) begin
                                    shift_r  <= rdByte_s[6:0];
                                    sdaLow_r <= ~rdByte_s[7];
                                    state_r  <= ST_RD_DATA;
                                end else if (state_r == ST_DEV_ACK) begin
                                    state_r <= ST_REG_ADDR;
                                end else begin
                                    state_r <= ST_WR_DATA;
                                end
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        if (sclFall_s) begin
                            if (bitCnt_r == 3'd7) begin
                                sdaLow_r <= 1'b0;
                                bitCnt_r <= 3'd0;
                                state_r  <= ST_RD_ACK;
                            end else begin
                                sdaLow_r <= ~shift_r[6];
                                shift_r  <= {shift_r[5:0], 1'b0};
                                bitCnt_r <= bitCnt_r + 3'd1;
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        // ackOn_r marks a seen master ACK; the next byte is loaded at the following fall.
                        if (sclRise_s && !ackOn_r) begin
                            if (!sdaNow_s) begin
                                ackOn_r <= 1'b1;
                                ptr_r   <= ptr_r + PTR_ONE;
                            end else begin
                                state_r <= ST_IGNORE;
                                busy    <= 1'b0;
                            end
                        end else if (sclFall_s && ackOn_r) begin
                            ackOn_r  <= 1'b0;
                            bitCnt_r <= 3'd0;
                            shift_r  <= rdByte_s[6:0];
                            sdaLow_r <= ~rdByte_s[7];
                            state_r  <= ST_RD_DATA;
                        end
                    end
                    ST_IDLE, ST_IGNORE: begin
                        sdaLow_r <= 1'b0;
                    end
                    default: begin
                        state_r  <= ST_IDLE;
                        sdaLow_r <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
